// File: rtl/vj_cascade_pkg.sv
// Shared types for the Viola-Jones cascade engine: feature record layout,
// FSM state encoding and a rectangle bounds helper.
package vj_cascade_pkg;

  // The feature record layout is sized for the largest supported window.
  // Engines built with a smaller WIN_SIZE use the same record layout.
  localparam int VJ_WIN_SIZE = 24;
  localparam int VJ_ACC_W    = 32;
  localparam int CW          = $clog2(VJ_WIN_SIZE + 1);

  typedef struct packed {
    logic [CW-1:0]              x1;
    logic [CW-1:0]              y1;
    logic [CW-1:0]              x2;
    logic [CW-1:0]              y2;
    logic signed [VJ_ACC_W-1:0] w;
  } vj_rect_t;

  typedef struct packed {
    vj_rect_t [2:0]             rect;
    logic signed [VJ_ACC_W-1:0] ft;
    logic signed [VJ_ACC_W-1:0] fa;
    logic signed [VJ_ACC_W-1:0] fb;
    logic signed [VJ_ACC_W-1:0] st;
    logic                       is_stage_end;
  } vj_feat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EVAL,
    ST_ACC,
    ST_DONE
  } vj_state_t;

  function automatic logic rect_in_window(input logic [CW-1:0] x1, input logic [CW-1:0] y1,
                                          input logic [CW-1:0] x2, input logic [CW-1:0] y2,
                                          input int win_size);
    return (int'(x1) <= win_size) && (int'(y1) <= win_size) &&
           (int'(x2) <= win_size) && (int'(y2) <= win_size);
  endfunction

endpackage

// File: rtl/vj_cascade_engine_rect_sum.sv
// Four-corner integral-image lookup for one rectangle:
// r = ii[y2][x2] + ii[y1][x1] - ii[y1][x2] - ii[y2][x1], entries zero-extended.
module vj_rect_sum
  import vj_cascade_pkg::*;
#(
  parameter int WIN_SIZE = 24,
  parameter int II_W     = 18,
  parameter int ACC_W    = 32
) (
  input  logic [(WIN_SIZE+1)*(WIN_SIZE+1)*II_W-1:0] ii_i,
  input  logic [CW-1:0]                             x1_i,
  input  logic [CW-1:0]                             y1_i,
  input  logic [CW-1:0]                             x2_i,
  input  logic [CW-1:0]                             y2_i,
  output logic signed [ACC_W-1:0]                   r_o
);

  localparam int IIB = (WIN_SIZE + 1) * (WIN_SIZE + 1) * II_W;
  localparam int IW  = $clog2(IIB);

  // Row-major image: entry (x, y) sits at flat index y*(WIN_SIZE+1)+x.
  function automatic logic [ACC_W-1:0] corner(input logic [IIB-1:0] img,
                                              input logic [CW-1:0] cx,
                                              input logic [CW-1:0] cy);
    logic [IW-1:0] base;
    base = IW'((int'(cy) * (WIN_SIZE + 1) + int'(cx)) * II_W);
    return ACC_W'(img[base +: II_W]);
  endfunction

  // Wrapping add/subtract of the four corners.
  always_comb begin
    r_o = corner(ii_i, x2_i, y2_i) + corner(ii_i, x1_i, y1_i)
        - corner(ii_i, x2_i, y1_i) - corner(ii_i, x1_i, y2_i);
  end

endmodule

// File: rtl/vj_cascade_engine.sv
// Stallable, early-exit Viola-Jones cascade evaluator. One window in, one
// detection record out; features are fetched one every three clocks.
//
// state | meaning
// IDLE  | ready for a window
// FETCH | strobe feature read at current index
// EVAL  | capture feature record and the three rect sums
// ACC   | weigh feature, update stage accumulator, resolve stage end
// DONE  | hold result until consumed
module vj_cascade_engine
  import vj_cascade_pkg::*;
#(
  parameter int WIN_SIZE    = 24,
  parameter int II_W        = 18,
  parameter int ACC_W       = 32,
  parameter int NUM_FEATURE = 2913,
  parameter int FEAT_AW     = 12,
  parameter int POS_W       = 16
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      win_valid,
  output logic                                      win_ready,
  input  logic [(WIN_SIZE+1)*(WIN_SIZE+1)*II_W-1:0] win_ii,
  input  logic signed [ACC_W-1:0]                   win_std_dev,
  input  logic [POS_W-1:0]                          win_x,
  input  logic [POS_W-1:0]                          win_y,
  input  logic [3:0]                                win_scale,
  output logic                                      feat_rd,
  output logic [FEAT_AW-1:0]                        feat_addr,
  input  vj_feat_t                                  feat_data,
  output logic                                      res_valid,
  input  logic                                      res_ready,
  output logic                                      res_is_face,
  output logic [POS_W-1:0]                          res_x,
  output logic [POS_W-1:0]                          res_y,
  output logic [3:0]                                res_scale,
  output logic [7:0]                                res_stages,
  output logic signed [ACC_W-1:0]                   res_score,
  output logic                                      busy
);

  localparam int                 IIB      = (WIN_SIZE + 1) * (WIN_SIZE + 1) * II_W;
  localparam logic [FEAT_AW-1:0] LAST_IDX = FEAT_AW'(NUM_FEATURE - 1);

  vj_state_t                 state_q, state_d;
  logic [IIB-1:0]            ii_q, ii_d;
  logic signed [ACC_W-1:0]   std_q, std_d;
  logic [POS_W-1:0]          x_q, x_d, y_q, y_d;
  logic [3:0]                scale_q, scale_d;
  logic [FEAT_AW-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0]   sacc_q, sacc_d;
  logic [7:0]                stages_q, stages_d;
  logic signed [ACC_W-1:0]   w_q [3];
  logic signed [ACC_W-1:0]   w_d [3];
  logic signed [ACC_W-1:0]   r_q [3];
  logic signed [ACC_W-1:0]   r_d [3];
  logic signed [ACC_W-1:0]   r_w [3];
  logic signed [ACC_W-1:0]   ft_q, ft_d, fa_q, fa_d, fb_q, fb_d, st_q, st_d;
  logic                      end_q, end_d;
  logic                      face_q, face_d;
  logic signed [ACC_W-1:0]   score_q, score_d;

  logic signed [ACC_W-1:0]   fsum, thr, sacc;

  for (genvar g = 0; g < 3; g++) begin : g_rect
    vj_rect_sum #(.WIN_SIZE(WIN_SIZE), .II_W(II_W), .ACC_W(ACC_W)) u_rect_sum (
      .ii_i (ii_q),
      .x1_i (feat_data.rect[g].x1),
      .y1_i (feat_data.rect[g].y1),
      .x2_i (feat_data.rect[g].x2),
      .y2_i (feat_data.rect[g].y2),
      .r_o  (r_w[g])
    );
  end

  // Feature response and threshold; all products wrap to ACC_W bits.
  always_comb begin
    fsum = '0;
    for (int i = 0; i < 3; i++) fsum = fsum + w_q[i] * r_q[i];
    thr  = ft_q * std_q;
    sacc = sacc_q + ((fsum > thr) ? fa_q : fb_q);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    ii_d     = ii_q;
    std_d    = std_q;
    x_d      = x_q;
    y_d      = y_q;
    scale_d  = scale_q;
    idx_d    = idx_q;
    sacc_d   = sacc_q;
    stages_d = stages_q;
    w_d      = w_q;
    r_d      = r_q;
    ft_d     = ft_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    st_d     = st_q;
    end_d    = end_q;
    face_d   = face_q;
    score_d  = score_q;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          ii_d     = win_ii;
          std_d    = win_std_dev;
          x_d      = win_x;
          y_d      = win_y;
          scale_d  = win_scale;
          idx_d    = '0;
          sacc_d   = '0;
          stages_d = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_EVAL;
      ST_EVAL: begin
        for (int i = 0; i < 3; i++) begin
          w_d[i] = ACC_W'(feat_data.rect[i].w);
          r_d[i] = r_w[i];
        end
        ft_d    = ACC_W'(feat_data.ft);
        fa_d    = ACC_W'(feat_data.fa);
        fb_d    = ACC_W'(feat_data.fb);
        st_d    = ACC_W'(feat_data.st);
        end_d   = feat_data.is_stage_end;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        // The final feature always closes a stage, even if the record forgot to flag it.
        if (end_q || (idx_q == LAST_IDX)) begin
          if (sacc > st_q) begin
            stages_d = stages_q + 8'd1;
            sacc_d   = '0;
            if (idx_q == LAST_IDX) begin
              face_d  = 1'b1;
              score_d = sacc;
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + FEAT_AW'(1);
              state_d = ST_FETCH;
            end
          end else begin
            face_d  = 1'b0;
            score_d = sacc;
            state_d = ST_DONE;
          end
        end else begin
          sacc_d  = sacc;
          idx_d   = idx_q + FEAT_AW'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Window, feature and result registers; a reset discards any window in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ii_q     <= '0;
      std_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      scale_q  <= '0;
      idx_q    <= '0;
      sacc_q   <= '0;
      stages_q <= '0;
      w_q      <= '{default: '0};
      r_q      <= '{default: '0};
      ft_q     <= '0;
      fa_q     <= '0;
      fb_q     <= '0;
      st_q     <= '0;
      end_q    <= 1'b0;
      face_q   <= 1'b0;
      score_q  <= '0;
    end else begin
      ii_q     <= ii_d;
      std_q    <= std_d;
      x_q      <= x_d;
      y_q      <= y_d;
      scale_q  <= scale_d;
      idx_q    <= idx_d;
      sacc_q   <= sacc_d;
      stages_q <= stages_d;
      w_q      <= w_d;
      r_q      <= r_d;
      ft_q     <= ft_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      st_q     <= st_d;
      end_q    <= end_d;
      face_q   <= face_d;
      score_q  <= score_d;
    end
  end

  assign win_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign feat_rd     = (state_q == ST_FETCH);
  assign feat_addr   = feat_rd ? idx_q : '0;
  assign res_valid   = (state_q == ST_DONE);
  assign res_is_face = face_q;
  assign res_x       = x_q;
  assign res_y       = y_q;
  assign res_scale   = scale_q;
  assign res_stages  = stages_q;
  assign res_score   = score_q;

  // Rectangle corners outside the window indicate a malformed cascade.
  assert property (@(posedge clock) disable iff (reset)
    (state_q == ST_EVAL) |->
      (rect_in_window(feat_data.rect[0].x1, feat_data.rect[0].y1,
                      feat_data.rect[0].x2, feat_data.rect[0].y2, WIN_SIZE) &&
       rect_in_window(feat_data.rect[1].x1, feat_data.rect[1].y1,
                      feat_data.rect[1].x2, feat_data.rect[1].y2, WIN_SIZE) &&
       rect_in_window(feat_data.rect[2].x1, feat_data.rect[2].y1,
                      feat_data.rect[2].x2, feat_data.rect[2].y2, WIN_SIZE)));

endmodule

// File: doc/vj_cascade_engine.md
Name: vj_cascade_engine

Overview:
- Parametrised Viola-Jones cascade evaluator. Accepts one integral-image scan window through a valid/ready handshake.
- Walks the feature list through an external feature-memory read port, one feature every 3 clocks. Exits early at the first failed stage.
- Returns a detection record through a valid/ready result handshake.
- Sits between the scan-window generator and the detection collector. Replaces the fixed-size, free-running cascade pipeline with a stallable, early-exit, size-generic engine.

Parameters:
WIN_SIZE, 24, window edge in pixels; the integral image is (WIN_SIZE+1)x(WIN_SIZE+1)
II_W, 18, unsigned integral-image entry width
ACC_W, 32, signed width of weights, thresholds, products and accumulators
NUM_FEATURE, 2913, total features in the cascade
FEAT_AW, 12, feature address width; must satisfy 2**FEAT_AW >= NUM_FEATURE
POS_W, 16, window x/y coordinate width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
win_valid  in  1  window offered
win_ready  out  1  engine can accept a window
win_ii  in  (WIN_SIZE+1)*(WIN_SIZE+1)*II_W  integral image, row-major [y][x]
win_std_dev  in  ACC_W  window standard deviation
win_x, win_y  in  POS_W each  window top-left
win_scale  in  4  pyramid level
feat_rd  out  1  feature read strobe
feat_addr  out  FEAT_AW  feature index
feat_data  in  vj_feat_t width  feature record; valid exactly 1 clock after feat_rd
res_valid  out  1  result available
res_ready  in  1  result consumed
res_is_face  out  1  all stages passed
res_x, res_y  out  POS_W each  echoed coordinates
res_scale  out  4  echoed pyramid level
res_stages  out  8  stages passed
res_score  out  ACC_W  last compared stage accumulator
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0 except win_ready, which is 1 once reset deasserts. FSM goes to IDLE. Accumulators, feature index and window registers are cleared. Reset mid-evaluation discards the window and produces no result.
- FSM states: IDLE, FETCH, EVAL, ACC, DONE.
  - IDLE: win_ready=1. On win_valid, latch the window, std_dev, x, y and scale; set feature index=0, stage_acc=0, stages=0; go to FETCH.
  - FETCH: feat_rd=1 and feat_addr=index for this cycle only; go to EVAL.
  - EVAL: register feat_data. Register three rect sums, each r = ii[y2][x2] + ii[y1][x1] - ii[y1][x2] - ii[y2][x1], with II_W entries zero-extended to ACC_W. Go to ACC.
  - ACC: compute fsum = w1*r1 + w2*r2 + w3*r3 and thr = ft*std_dev. Products are signed and truncated to the low ACC_W bits. Add fa to stage_acc if fsum > thr (signed, strict), otherwise add fb. Call the updated value sacc.
  - Stage end: applies when is_stage_end=1 or index = NUM_FEATURE-1 (forced).
    - If sacc > st (signed, strict): stages++, stage_acc := 0, continue.
    - Otherwise: reject. res_is_face=0, res_score=sacc, go to DONE.
  - Pass at index = NUM_FEATURE-1: res_is_face=1, res_score=sacc, go to DONE. Otherwise index++ and go to FETCH.
  - DONE: res_valid=1. All res_* fields are held stable until res_ready. On res_ready, go to IDLE.
- win_ready=0 outside IDLE, and win_valid is ignored there. A window is accepted no earlier than the cycle after the result handshake.
- Latency: evaluating k features puts res_valid high 3k clocks after the acceptance edge. There is exactly one feat_rd per evaluated feature.
- Accumulator overflow wraps (two's complement); no saturation.
- Rect coordinates must be <= WIN_SIZE. A simulation-only assertion flags violations; RTL behaviour on a violation is unspecified.

Decomposition:
- Package vj_cascade_pkg holds:
  - coordinate width CW = $clog2(WIN_SIZE+1).
  - vj_rect_t: x1, y1, x2, y2, w.
  - vj_feat_t: rect[3], ft, fa, fb, st, is_stage_end.
  - the state enum.
- One sub-module, vj_rect_sum: combinational four-corner lookup and add/subtract for one rectangle, instantiated 3 times.

Test Plan:
All scenarios use WIN_SIZE=4, NUM_FEATURE=4, win_ii[y][x]=x*y (all-ones image) and win_std_dev=1. Every feature uses rect1=(0,0)-(2,2) with w=1 and other weights 0 (r1=4), ft=0, fa=10, fb=-3, and is_stage_end set on features 1 and 3. Only st varies per scenario.

1. Reset asserted mid-FETCH of feature 2 -> all outputs 0, busy=0, win_ready=1 after release. The next window starts at feat_addr=0.
2. st=15 for all -> res_is_face=1, res_stages=2, res_score=20. Exactly 4 feat_rd pulses; res_valid 12 clocks after acceptance.
3. Feature 1 st=25 -> reject: res_is_face=0, res_stages=0, res_score=20. 2 feat_rd pulses; res_valid at 6 clocks.
4. Feature 1 st=20 (tie) -> reject, showing the comparison is strict. Then ft=5 on all features: fsum 4 > thr 5 is false, so fb applies, stage_acc=-6; with st=-7 the window passes (signed), res_score=-6.
5. res_ready held low 10 clocks in DONE with win_valid=1 -> res_* fields stable, win_ready=0, no accept. Raise res_ready -> IDLE next clock, window accepted the clock after.
6. Back-to-back windows with win_x=3/7 and scale=1/2 -> results echo 3/1 then 7/2 in order, with no lost or duplicated res_valid.
